// File: rtl/seq_scan_ctrl_if.sv
// Bus bundle for seq_scan_ctrl: scan request in, scan status/results out.
// hit_map exists only when SEQ_SCAN_HITMAP_EN is defined.
interface seq_scan_ctrl_if;
  logic        start;
  logic [31:0] data_in;
  logic [3:0]  pattern;
  logic        busy;
  logic        done;
  logic        hit;
  logic [5:0]  hit_cnt;
  logic [4:0]  first_pos;
  logic        first_valid;
`ifdef SEQ_SCAN_HITMAP_EN
  logic [31:0] hit_map;
`endif

  modport master (
    output start, data_in, pattern,
    input  busy, done, hit, hit_cnt, first_pos, first_valid
`ifdef SEQ_SCAN_HITMAP_EN
    , input hit_map
`endif
  );

  modport slave (
    input  start, data_in, pattern,
    output busy, done, hit, hit_cnt, first_pos, first_valid
`ifdef SEQ_SCAN_HITMAP_EN
    , output hit_map
`endif
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Scans a captured 32-bit word MSB-first for overlapping 4-bit pattern matches.
// Optional per-index hit map is enabled with SEQ_SCAN_HITMAP_EN.
module seq_scan_ctrl (
  input  logic           clk,
  input  logic           reset,
  seq_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  pat_q, pat_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  win_q, win_d;
  logic        hit_q, hit_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  fpos_q, fpos_d;
  logic        fval_q, fval_d;
`ifdef SEQ_SCAN_HITMAP_EN
  logic [31:0] map_q, map_d;
`endif

  logic cur_bit, match;

  // 31-idx is the bitwise complement of a 5-bit index
  assign cur_bit = word_q[~idx_q];
  assign match   = (idx_q >= 5'd3) && ({win_q, cur_bit} == pat_q);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    win_d   = win_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    fpos_d  = fpos_q;
    fval_d  = fval_q;
`ifdef SEQ_SCAN_HITMAP_EN
    map_d   = map_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SCAN;
          word_d  = bus.data_in;
          pat_d   = bus.pattern;
          idx_d   = '0;
          win_d   = '0;
          cnt_d   = '0;
          fpos_d  = '0;
          fval_d  = 1'b0;
`ifdef SEQ_SCAN_HITMAP_EN
          map_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        win_d = {win_q[1:0], cur_bit};
        idx_d = idx_q + 5'd1;
        if (match) begin
          hit_d = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (!fval_q) begin
            fpos_d = idx_q;
            fval_d = 1'b1;
          end
`ifdef SEQ_SCAN_HITMAP_EN
          map_d[idx_q] = 1'b1;
`endif
        end
        if (idx_q == 5'd31) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      win_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      fpos_q  <= '0;
      fval_q  <= 1'b0;
`ifdef SEQ_SCAN_HITMAP_EN
      map_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      fpos_q  <= fpos_d;
      fval_q  <= fval_d;
`ifdef SEQ_SCAN_HITMAP_EN
      map_q   <= map_d;
`endif
    end
  end

  assign bus.busy        = (state_q == SCAN);
  assign bus.done        = (state_q == DONE);
  assign bus.hit         = hit_q;
  assign bus.hit_cnt     = cnt_q;
  assign bus.first_pos   = fpos_q;
  assign bus.first_valid = fval_q;
`ifdef SEQ_SCAN_HITMAP_EN
  assign bus.hit_map     = map_q;
`endif
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed vectors, back-to-back,
// mid-scan reset and randomized scans against a slice-based reference model.
module tb_seq_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_scan_ctrl_if bus ();
  seq_scan_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // A match ends at idx when the 4 bits scanned at idx-3..idx equal the pattern.
  function automatic bit model_hit(input logic [31:0] w, input logic [3:0] p, input int idx);
    logic [31:0] sh;
    if (idx < 3) return 1'b0;
    sh = w >> (31 - idx);
    return sh[3:0] == p;
  endfunction

  task automatic launch(input logic [31:0] w, input logic [3:0] p);
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = w; bus.pattern = p;
    @(posedge clk); #1;
  endtask

  // Entered #1 after the accepting edge; checks every cycle up to and after done.
  task automatic scan_body(input logic [31:0] w, input logic [3:0] p, input int inject,
                           input bit chain, input logic [31:0] nw, input logic [3:0] np);
    int cnt = 0; int fpos = 0; bit fval = 0; bit eh;
    logic [31:0] map = '0;
    bus.start = 1'b0;
    for (int k = -1; k < 32; k++) begin
      eh = 1'b0;
      if (k >= 0) begin
        if (k == inject) begin
          bus.start = 1'b1; bus.data_in = $urandom; bus.pattern = ~p;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        eh = model_hit(w, p, k);
        if (eh) begin
          cnt++; map[k] = 1'b1;
          if (!fval) begin fval = 1'b1; fpos = k; end
        end
      end
      checks++; if (bus.hit !== eh) begin errors++; $display("FAIL hit k=%0d got %b exp %b", k, bus.hit, eh); end
      checks++; if (bus.hit_cnt !== 6'(cnt)) begin errors++; $display("FAIL hit_cnt k=%0d got %0d exp %0d", k, bus.hit_cnt, cnt); end
      checks++; if (bus.first_valid !== fval) begin errors++; $display("FAIL first_valid k=%0d got %b exp %b", k, bus.first_valid, fval); end
      checks++; if (bus.first_pos !== 5'(fpos)) begin errors++; $display("FAIL first_pos k=%0d got %0d exp %0d", k, bus.first_pos, fpos); end
      checks++; if (bus.busy !== (k < 31)) begin errors++; $display("FAIL busy k=%0d got %b", k, bus.busy); end
      checks++; if (bus.done !== (k == 31)) begin errors++; $display("FAIL done k=%0d got %b", k, bus.done); end
`ifdef SEQ_SCAN_HITMAP_EN
      checks++; if (bus.hit_map !== map) begin errors++; $display("FAIL hit_map k=%0d got %h exp %h", k, bus.hit_map, map); end
`endif
    end
    if (chain) begin
      bus.start = 1'b1; bus.data_in = nw; bus.pattern = np;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL idle_after_done got done=%b busy=%b hit=%b", bus.done, bus.busy, bus.hit); end
      checks++; if (bus.hit_cnt !== 6'(cnt) || bus.first_pos !== 5'(fpos) || bus.first_valid !== fval) begin errors++; $display("FAIL hold_after_done got cnt=%0d pos=%0d val=%b", bus.hit_cnt, bus.first_pos, bus.first_valid); end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.data_in = '0; bus.pattern = '0;
    reset = 1'b1;
    #2;
    checks++; if ({bus.busy, bus.done, bus.hit, bus.first_valid} !== 4'b0 || bus.hit_cnt !== 6'd0 || bus.first_pos !== 5'd0) begin errors++; $display("FAIL reset_state busy=%b done=%b hit=%b cnt=%0d", bus.busy, bus.done, bus.hit, bus.hit_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b done=%b", bus.busy, bus.done); end
  endtask

  task automatic test_vector_a;
    launch(32'b00100101010111010010010101011101, 4'b0101);
    scan_body(32'b00100101010111010010010101011101, 4'b0101, -1, 1'b0, '0, '0);
    checks++; if (bus.hit_cnt !== 6'd6 || bus.first_pos !== 5'd7 || bus.first_valid !== 1'b1) begin errors++; $display("FAIL vector_a cnt=%0d pos=%0d val=%b exp 6 7 1", bus.hit_cnt, bus.first_pos, bus.first_valid); end
`ifdef SEQ_SCAN_HITMAP_EN
    checks++; if (bus.hit_map !== 32'h0A800A80) begin errors++; $display("FAIL vector_a_map got %h exp 0a800a80", bus.hit_map); end
`endif
  endtask

  task automatic test_all_zero;
    launch(32'h0, 4'b0000);
    scan_body(32'h0, 4'b0000, -1, 1'b0, '0, '0);
    checks++; if (bus.hit_cnt !== 6'd29 || bus.first_pos !== 5'd3) begin errors++; $display("FAIL all_zero cnt=%0d pos=%0d exp 29 3", bus.hit_cnt, bus.first_pos); end
  endtask

  task automatic test_all_ones;
    launch(32'hFFFFFFFF, 4'b0101);
    scan_body(32'hFFFFFFFF, 4'b0101, -1, 1'b0, '0, '0);
    checks++; if (bus.hit_cnt !== 6'd0 || bus.first_valid !== 1'b0 || bus.first_pos !== 5'd0) begin errors++; $display("FAIL all_ones cnt=%0d val=%b pos=%0d exp 0", bus.hit_cnt, bus.first_valid, bus.first_pos); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w2;
    w2 = 32'h0F0F0F0F;
    launch(32'hA5A5A5A5, 4'b1010);
    scan_body(32'hA5A5A5A5, 4'b1010, 10, 1'b1, w2, 4'b0011);
    scan_body(w2, 4'b0011, -1, 1'b0, '0, '0);
  endtask

  task automatic test_reset_midscan;
    launch(32'h0, 4'b0000);
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    checks++; if (bus.hit_cnt !== 6'd13 || bus.busy !== 1'b1) begin errors++; $display("FAIL pre_reset cnt=%0d busy=%b exp 13 1", bus.hit_cnt, bus.busy); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.hit, bus.first_valid} !== 4'b0 || bus.hit_cnt !== 6'd0 || bus.first_pos !== 5'd0) begin errors++; $display("FAIL async_reset busy=%b done=%b hit=%b cnt=%0d pos=%0d", bus.busy, bus.done, bus.hit, bus.hit_cnt, bus.first_pos); end
`ifdef SEQ_SCAN_HITMAP_EN
    checks++; if (bus.hit_map !== 32'h0) begin errors++; $display("FAIL async_reset_map got %h", bus.hit_map); end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL no_resume c=%0d busy=%b done=%b hit=%b", i, bus.busy, bus.done, bus.hit); end
    end
    launch(32'h12345678, 4'b0110);
    scan_body(32'h12345678, 4'b0110, -1, 1'b0, '0, '0);
  endtask

  task automatic test_random;
    logic [31:0] w, nw;
    logic [3:0]  p, np, nib;
    bit ch;
    nib = 4'($urandom_range(0, 15));
    w = {8{nib}}; p = 4'($urandom_range(0, 15));
    launch(w, p);
    for (int i = 0; i < 20; i++) begin
      nib = 4'($urandom_range(0, 15));
      nw = (i % 2 == 0) ? $urandom : {8{nib}};
      np = 4'($urandom_range(0, 15));
      ch = (i % 3 == 1) && (i < 19);
      scan_body(w, p, (i % 5 == 2) ? int'($urandom_range(0, 30)) : -1, ch, nw, np);
      if (i < 19) begin
        if (!ch) launch(nw, np);
        w = nw; p = np;
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector_a();
    test_all_zero();
    test_all_ones();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
